// File: rtl/cic_integrator_chain.sv
// Valid-qualified cascade of CIC integrators with per-channel accumulators.
// Each stage is one register deep; out_* are the final stage's registers.

module cic_stage #(
  parameter int ODW    = 24,
  parameter int CW     = 1,
  parameter int SAT_EN = 0
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clear,
  input  logic           in_valid,
  input  logic [CW-1:0]  in_chan,
  input  logic [ODW-1:0] in_data,
  output logic           out_valid,
  output logic [CW-1:0]  out_chan,
  output logic [ODW-1:0] out_data,
  output logic           clamp
);
  localparam int NCH = 1 << CW;

  logic [ODW-1:0] acc [NCH];
  logic [ODW:0]   sum;
  logic [ODW-1:0] res;
  logic           clamp_c;

  // One guard bit is enough to detect overflow of a two-operand add.
  always_comb begin
    sum     = {acc[in_chan][ODW-1], acc[in_chan]} + {in_data[ODW-1], in_data};
    res     = sum[ODW-1:0];
    clamp_c = 1'b0;
    if (SAT_EN != 0 && sum[ODW] != sum[ODW-1]) begin
      clamp_c = 1'b1;
      res     = sum[ODW] ? {1'b1, {(ODW-1){1'b0}}} : {1'b0, {(ODW-1){1'b1}}};
    end
  end

  assign clamp = in_valid & clamp_c;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      for (int i = 0; i < NCH; i++) acc[i] <= '0;
      out_valid <= 1'b0;
      out_chan  <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        acc[in_chan] <= res;
        out_chan     <= in_chan;
        out_data     <= res;
      end
    end
  end
endmodule

module cic_integrator_chain #(
  parameter int IDW      = 8,
  parameter int ODW      = 24,
  parameter int STAGES   = 3,
  parameter int CHANNELS = 1,
  parameter int SAT_EN   = 0,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clear,
  input  logic           in_valid,
  input  logic [CW-1:0]  in_chan,
  input  logic [IDW-1:0] data_in,
  output logic           out_valid,
  output logic [CW-1:0]  out_chan,
  output logic [ODW-1:0] data_out,
  output logic           overflow
);
  logic [STAGES:0]           vld_pipe;
  logic [STAGES:0][CW-1:0]   chan_pipe;
  logic [STAGES:0][ODW-1:0]  data_pipe;
  logic [STAGES-1:0]         clamp;
  logic [(1<<CW)-1:0]        chan_ok;

  // Out-of-range channel codes are turned into bubbles before stage 1.
  for (genvar i = 0; i < (1 << CW); i++) begin : g_ok
    assign chan_ok[i] = (i < CHANNELS);
  end

  assign vld_pipe[0]  = in_valid & chan_ok[in_chan];
  assign chan_pipe[0] = in_chan;
  assign data_pipe[0] = ODW'($signed(data_in));

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cic_stage #(.ODW(ODW), .CW(CW), .SAT_EN(SAT_EN)) u_stage (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear),
      .in_valid  (vld_pipe[k]),
      .in_chan   (chan_pipe[k]),
      .in_data   (data_pipe[k]),
      .out_valid (vld_pipe[k+1]),
      .out_chan  (chan_pipe[k+1]),
      .out_data  (data_pipe[k+1]),
      .clamp     (clamp[k])
    );
  end

  assign out_valid = vld_pipe[STAGES];
  assign out_chan  = chan_pipe[STAGES];
  assign data_out  = data_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (!reset_n || clear) overflow <= 1'b0;
    else if (|clamp)       overflow <= 1'b1;
  end
endmodule

// File: doc/cic_integrator_chain.md
Name: cic_integrator_chain

Overview:
Parametrised cascade of STAGES integrators for the CIC decimator front end. Replaces the single free-running integrator with a pipelined, valid-qualified chain. Supports up to CHANNELS time-interleaved channels with independent per-channel accumulators and selectable wrap or saturate arithmetic. Feeds the decimator/comb section, which consumes out_valid/out_chan/data_out.

Parameters:
IDW, 8, input sample width (signed two's complement)
ODW, 24, accumulator/output width (signed); ODW >= IDW required
STAGES, 3, number of cascaded integrator stages (>= 1)
CHANNELS, 1, number of interleaved channels (>= 1)
SAT_EN, 0, 0 = modulo-2^ODW wrap (CIC-correct), 1 = saturate at each stage
CW (derived), max(1, clog2(CHANNELS)), channel index width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  reset
clear  in  1  synchronous clear of all accumulators, pipeline and overflow flag
in_valid  in  1  data_in/in_chan valid this cycle
in_chan  in  CW  channel index of data_in
data_in  in  IDW  signed input sample
out_valid  out  1  data_out/out_chan valid (registered)
out_chan  out  CW  channel index of data_out
data_out  out  ODW  signed output of final stage
overflow  out  1  sticky: some stage clamped (SAT_EN=1 only)

Behaviour:
- Reset is reset_n, synchronous, active-low; clock is clk.
- Reset: all accumulators = 0, all pipeline valid bits = 0, out_valid = 0, out_chan = 0, data_out = 0, overflow = 0. In-flight samples are discarded.
- data_in is sign-extended to ODW before stage 1.
- Stage k (1..STAGES) keeps acc_k[c] for each channel c, plus a pipeline register (value, chan, valid).
- Stage 1 on a clock edge with in_valid=1: acc_1[c] <= acc_1[c] + x and the stage register captures the new sum.
- Stage k>1 updates one cycle after stage k-1, using stage k-1's registered value and chan.
- Latency: a sample accepted at edge t produces out_valid=1 with its final-stage sum after edge t+STAGES-1. Throughput is 1 sample/cycle with no backpressure.
- Bubbles: in_valid=0 propagates as valid=0. Stages with valid=0 do not change any accumulator. out_valid=0 and data_out/out_chan hold their last values.
- Back-to-back samples on the same channel are legal. Each stage has updated its acc_k[c] before the next sample on channel c reaches it, so no hazard and no stall.
- in_chan >= CHANNELS: sample dropped; no accumulator changes; no out_valid.
- SAT_EN=0: each stage sum is truncated modulo 2^ODW (wrap); overflow stays 0.
- SAT_EN=1: each stage sum is clamped to [-2^(ODW-1), 2^(ODW-1)-1]. Any clamp on a valid update sets overflow, which holds until clear or reset.
- clear=1: same effect as reset, except the port is separate. clear has priority over an in_valid sample in the same cycle; that sample is dropped.
- CHANNELS=1, STAGES=1, SAT_EN=0, ODW=IDW+1 with in_valid tied high reproduces the legacy single integrator exactly.

Test Plan:
1. STAGES=1, CHANNELS=1, SAT_EN=0, ODW=9: data_in 1,2,3 on consecutive valid cycles -> data_out 1,3,6, each with out_valid=1 one cycle after the corresponding input.
2. STAGES=3, ODW=24: impulse 1 then zeros, continuous valid -> data_out 1,3,6,10,15,21. First out_valid appears 3 cycles after the impulse.
3. CHANNELS=2, STAGES=1: alternate ch0 data 1 and ch1 data -1, 6 samples -> ch0 outputs 1,2,3; ch1 outputs -1,-2,-3; out_chan alternates 0,1.
4. IDW=8, ODW=9, STAGES=1, constant 127:
   - SAT_EN=0 -> data_out 127, 254, -131; overflow=0.
   - SAT_EN=1 -> data_out 127, 254, 255, 255; overflow rises with the third output and stays high.
5. STAGES=3: drive constant 1, then assert clear together with in_valid=1 (data 5) -> that sample is dropped. Next valid input 2 yields final output 2 after 3 cycles. Repeat with reset_n=0 mid-stream -> all outputs 0, overflow 0.
6. Bubbles: valid pattern 1,0,0,1 with data 4,x,x,4 -> out_valid pattern matches, delayed by latency; data_out holds during bubbles. A sample with in_chan=CHANNELS -> no out_valid and accumulators unchanged.
